keypad_scan_ctrl: RTL

//  Scan controller for the 4x4 matrix keypad (1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D).

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_stable_timer.sv | 29 ++
 rtl/keypad_scan_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and decode helpers for the 4x4 keypad scanner.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] ROW0 = 4'b0001;
    localparam logic [3:0] ROW1 = 4'b0010;
    localparam logic [3:0] ROW2 = 4'b0100;
    localparam logic [3:0] ROW3 = 4'b1000;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    function automatic logic onehot4(input logic [3:0] col);
        return (col != 4'b0) && ((col & (col - 4'd1)) == 4'b0);
    endfunction

    // Rows 0-2 hold digits 1-9 row-major; right column is A-D.
    function automatic logic [3:0] decode_key(
        input logic [1:0] row_idx,
        input logic [3:0] col
    );
        logic [3:0] r;
        logic [3:0] code;
        r    = {2'b00, row_idx};
        code = 4'h0;
        case (col)
            4'b1000: code = (row_idx == 2'd3) ? KEY_STAR : r * 4'd3 + 4'd1;
            4'b0100: code = (row_idx == 2'd3) ? 4'h0 : r * 4'd3 + 4'd2;
            4'b0010: code = (row_idx == 2'd3) ? KEY_HASH : r * 4'd3 + 4'd3;
            4'b0001: code = 4'hA + r;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_stable_timer.sv
// Counts consecutive enabled cycles up to N; done stays high once N is reached.
// Any clear restarts the count from zero.
module keypad_stable_timer #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int W = $clog2(N + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != W'(N)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == W'(N));

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row drive, column sync, press/release debounce, valid/ack.
// Define KEYPAD_REPEAT_EN to add hold-to-repeat re-emission.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 250000
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DLY  = 25000000,
    parameter int REPEAT_RATE = 5000000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] key_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       key_overrun
);

    localparam int DW = $clog2(SCAN_DIV);

    state_t        state, state_nx;
    logic [3:0]    sync1, col_s, col_lat;
    logic [1:0]    row_idx;
    logic [DW-1:0] dwell;
    logic          dwell_end, col_ok, col_match, col_zero;
    logic          press_done, rel_done;
    logic          rotate, latch, accept, released;
    logic          rep_fire, emit_q;

    assign dwell_end = (dwell == DW'(SCAN_DIV - 1));
    assign col_ok    = onehot4(col_s);
    assign col_match = (col_s == col_lat);
    assign col_zero  = (col_s == 4'b0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= SCAN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SCAN:     if (dwell_end && col_ok) state_nx = DEBOUNCE;
            DEBOUNCE: if (!col_match)          state_nx = SCAN;
                      else if (press_done)     state_nx = HELD;
            HELD:     if (rel_done)            state_nx = SCAN;
            default:                           state_nx = SCAN;
        endcase
    end

    always_comb begin
        rotate   = 1'b0;
        latch    = 1'b0;
        accept   = 1'b0;
        released = 1'b0;
        unique case (state)
            SCAN: begin
                latch  = dwell_end && col_ok;
                rotate = dwell_end && !col_ok;
            end
            DEBOUNCE: begin
                rotate = !col_match;
                accept = col_match && press_done;
            end
            HELD: begin
                rotate   = rel_done;
                released = rel_done;
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (row_idx)
            2'd0: key_out = ROW0;
            2'd1: key_out = ROW1;
            2'd2: key_out = ROW2;
            2'd3: key_out = ROW3;
            default: key_out = ROW0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 4'b0;
            col_s   <= 4'b0;
            col_lat <= 4'b0;
            row_idx <= 2'd0;
            dwell   <= '0;
        end else begin
            sync1 <= key_in;
            col_s <= sync1;
            if (rotate) row_idx <= row_idx + 2'd1;
            if (latch)  col_lat <= col_s;
            if (state != SCAN || dwell_end) dwell <= '0;
            else                            dwell <= dwell + 1'b1;
        end
    end

    keypad_stable_timer #(.N(DB_CYCLES)) u_press (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != DEBOUNCE || !col_match),
        .en    (col_match),
        .done  (press_done)
    );

    keypad_stable_timer #(.N(DB_CYCLES)) u_release (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != HELD || !col_zero),
        .en    (col_zero),
        .done  (rel_done)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);

    logic [RW-1:0] rep_cnt;
    logic          rep_first, rep_end, rep_rst;
    logic [3:0]    col_q;

    assign rep_end  = rep_first ? (rep_cnt == RW'(REPEAT_DLY - 1))
                                : (rep_cnt == RW'(REPEAT_RATE - 1));
    assign rep_rst  = (state != HELD) || col_zero || (col_s != col_q);
    assign rep_fire = !rep_rst && rep_end;

    // Column change or start of release restarts the full initial delay.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q     <= 4'b0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            col_q <= col_s;
            if (rep_rst) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (rep_end) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            emit_q      <= 1'b0;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            emit_q <= accept || rep_fire;
            if (emit_q) begin
                key_code  <= decode_key(row_idx, col_lat);
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                if (key_valid && !key_ack) key_overrun <= 1'b1;
                else if (key_ack)          key_overrun <= 1'b0;
            end else if (key_valid && key_ack) begin
                key_valid   <= 1'b0;
                key_overrun <= 1'b0;
            end
            if (released) key_down <= 1'b0;
        end
    end

endmodule
